branch_predict_unit: RTL

//  Next-generation branch unit for the RISK core: resolves conditional

---
 rtl/branch_predict_unit.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/branch_predict_unit.sv
// Branch resolve + 2-bit-counter branch history table.
// After reset an init sweep writes INIT_CNT into every BHT entry. Both ports
// ignore requests until the sweep is done. Resolve and predict results are
// registered with 1-cycle latency. The BHT is read before it is written, so a
// same-cycle predict on an index that is being updated returns the old value.
module branch_predict_unit #(
   parameter int         XLEN     = 32,
   parameter int         IDX_W    = 6,
   parameter logic [1:0] INIT_CNT = 2'b01
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   output logic            o_ready,
   input  logic            i_pred_valid,
   input  logic [XLEN-1:0] i_pred_pc,
   output logic            o_pred_valid,
   output logic            o_pred_taken,
   input  logic            i_res_valid,
   input  logic [XLEN-1:0] i_res_pc,
   input  logic [XLEN-1:0] i_res_dat_a,
   input  logic [XLEN-1:0] i_res_dat_b,
   input  logic [2:0]      i_res_funct3,
   input  logic [4:0]      i_res_opcode,
   input  logic            i_res_pred_taken,
   output logic            o_res_valid,
   output logic            o_br_en,
   output logic            o_mispredict
);

   localparam int ENTRIES = 2 ** IDX_W;

   localparam logic [4:0] OP_BRANCH = 5'b11000;
   localparam logic [4:0] OP_JAL    = 5'b11011;
   localparam logic [4:0] OP_JALR   = 5'b11001;

   typedef enum logic {ST_INIT, ST_RUN} state_e;

   state_e           state_q, state_d;
   logic [IDX_W-1:0] ptr_q, ptr_d;

   // Contents are deliberately not reset; the init sweep overwrites them.
   logic [1:0]       bht [ENTRIES];

   logic             pred_valid_q, pred_valid_d;
   logic             pred_taken_q, pred_taken_d;
   logic             res_valid_q, res_valid_d;
   logic             br_en_q, br_en_d;
   logic             mispredict_q, mispredict_d;

   logic             ready;
   logic             pred_acc, res_acc;
   logic [IDX_W-1:0] pred_idx, res_idx;
   logic [1:0]       pred_cnt, res_cnt;
   logic             cond, cond_r, is_jump, is_br, taken;
   logic             bht_we;
   logic [IDX_W-1:0] bht_widx;
   logic [1:0]       bht_wdat;

   assign ready    = (state_q == ST_RUN);
   assign pred_acc = ready & i_pred_valid;
   assign res_acc  = ready & i_res_valid;
   assign pred_idx = i_pred_pc[IDX_W+1:2];
   assign res_idx  = i_res_pc[IDX_W+1:2];
   assign pred_cnt = bht[pred_idx];
   assign res_cnt  = bht[res_idx];

   // Init sweep: one entry per cycle, then stay in RUN until reset.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      if (state_q == ST_INIT) begin
         ptr_d = ptr_q + 1'b1;
         if (ptr_q == {IDX_W{1'b1}}) state_d = ST_RUN;
      end
   end

   // Condition decode and registered-result next values.
   always_comb begin
      unique case (i_res_funct3[2:1])
         2'b00:   cond = (i_res_dat_a == i_res_dat_b);
         2'b10:   cond = ($signed(i_res_dat_a) < $signed(i_res_dat_b));
         2'b11:   cond = (i_res_dat_a < i_res_dat_b);
         default: cond = 1'b0;
      endcase
      cond_r  = cond ^ i_res_funct3[0];
      is_jump = (i_res_opcode == OP_JAL) || (i_res_opcode == OP_JALR);
      is_br   = (i_res_opcode == OP_BRANCH) && (i_res_funct3[2:1] != 2'b01);
      taken   = is_jump | cond_r;

      res_valid_d  = res_acc;
      br_en_d      = res_acc & (is_jump | (is_br & cond_r));
      // Illegal / unknown ops never flag a mispredict.
      mispredict_d = res_acc & (is_jump | is_br) & (taken != i_res_pred_taken);

      pred_valid_d = pred_acc;
      pred_taken_d = pred_acc & pred_cnt[1];
   end

   // BHT write port: sweep writes during INIT, saturating update on branches.
   always_comb begin
      bht_we   = 1'b0;
      bht_widx = res_idx;
      bht_wdat = res_cnt;
      if (state_q == ST_INIT) begin
         bht_we   = 1'b1;
         bht_widx = ptr_q;
         bht_wdat = INIT_CNT;
      end else if (res_acc && is_br) begin
         bht_we = 1'b1;
         if (cond_r) bht_wdat = (res_cnt == 2'b11) ? 2'b11 : res_cnt + 2'b01;
         else        bht_wdat = (res_cnt == 2'b00) ? 2'b00 : res_cnt - 2'b01;
      end
   end

   // BHT storage, no reset.
   always_ff @(posedge i_clk) begin
      if (bht_we) bht[bht_widx] <= bht_wdat;
   end

   // Control and result registers.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q      <= ST_INIT;
         ptr_q        <= '0;
         pred_valid_q <= 1'b0;
         pred_taken_q <= 1'b0;
         res_valid_q  <= 1'b0;
         br_en_q      <= 1'b0;
         mispredict_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         ptr_q        <= ptr_d;
         pred_valid_q <= pred_valid_d;
         pred_taken_q <= pred_taken_d;
         res_valid_q  <= res_valid_d;
         br_en_q      <= br_en_d;
         mispredict_q <= mispredict_d;
      end
   end

   assign o_ready      = ready;
   assign o_pred_valid = pred_valid_q;
   assign o_pred_taken = pred_taken_q;
   assign o_res_valid  = res_valid_q;
   assign o_br_en      = br_en_q;
   assign o_mispredict = mispredict_q;

endmodule
